// File: rtl/ariane_pkg.sv
// Shared frontend types: the fetch entry handed to the ID stage and the
// default aging threshold of the ID fetch arbiter.
package ariane_pkg;

    localparam int unsigned FetchArbMaxWait = 3;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
        logic        ex_valid;
    } fetch_entry_t;

endpackage

// File: rtl/age_prio_arbiter.sv
// Fixed-priority arbiter (index 0 highest) with per-requester wait counters;
// a requester that has lost MaxWait arbitrations in a row becomes urgent.
module age_prio_arbiter #(
    parameter int unsigned NrSrc   = 2,
    parameter int unsigned MaxWait = 3,
    parameter int unsigned SrcIdxW = (NrSrc > 1) ? $clog2(NrSrc) : 1,
    parameter int unsigned AgeW    = $clog2(MaxWait + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NrSrc-1:0]   req_i,
    input  logic               advance_i,
    input  logic               flush_i,
    output logic [NrSrc-1:0]   gnt_o,
    output logic [SrcIdxW-1:0] gnt_idx_o,
    output logic               gnt_valid_o
);

    localparam logic [AgeW-1:0] MaxAge = AgeW'(MaxWait);

    logic [NrSrc-1:0][AgeW-1:0] age_q, age_d;
    logic [NrSrc-1:0]           urgent_s;
    logic [NrSrc-1:0]           cand_s;

    // Urgent requesters pre-empt the plain fixed-priority order.
    always_comb begin
        urgent_s    = {NrSrc{1'b0}};
        gnt_idx_o   = {SrcIdxW{1'b0}};
        for (int i = 0; i < NrSrc; i++) begin
            urgent_s[i] = req_i[i] && (age_q[i] == MaxAge);
        end
        cand_s      = (|urgent_s) ? urgent_s : req_i;
        for (int i = NrSrc - 1; i >= 0; i--) begin
            gnt_idx_o = cand_s[i] ? SrcIdxW'(i) : gnt_idx_o;
        end
        gnt_valid_o = |cand_s;
        gnt_o       = gnt_valid_o ? (NrSrc'(1) << gnt_idx_o) : {NrSrc{1'b0}};
    end

    // Wait counter next state; a dropped request forgets its accumulated age.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NrSrc; i++) begin
            if (flush_i) begin
                age_d[i] = {AgeW{1'b0}};
            end else if (advance_i && gnt_valid_o) begin
                if (gnt_o[i]) begin
                    age_d[i] = {AgeW{1'b0}};
                end else if (req_i[i]) begin
                    age_d[i] = (age_q[i] == MaxAge) ? MaxAge : age_q[i] + AgeW'(1);
                end else begin
                    age_d[i] = {AgeW{1'b0}};
                end
            end else begin
                age_d[i] = req_i[i] ? age_q[i] : {AgeW{1'b0}};
            end
        end
    end

    // Wait counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/id_fetch_arbiter_sva.sv
// Protocol checks for the ID fetch arbiter outputs.
module id_fetch_arbiter_sva
    import ariane_pkg::*;
#(
    parameter int unsigned NrSrc   = 2,
    parameter int unsigned SrcIdxW = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [NrSrc-1:0]   src_valid_i,
    input  logic [NrSrc-1:0]   src_ready_o,
    input  fetch_entry_t       fetch_entry_o,
    input  logic               fetch_entry_valid_o,
    input  logic               fetch_entry_ready_i,
    input  logic [SrcIdxW-1:0] src_id_o
);

    logic               hold_s;
    logic               prev_hold_q;
    fetch_entry_t       prev_entry_q;
    logic [SrcIdxW-1:0] prev_id_q;

    assign hold_s = rst_ni && !flush_i && fetch_entry_valid_o && !fetch_entry_ready_i;

    // Remember a stalled output so the following cycle can be compared with it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_hold_q  <= 1'b0;
            prev_entry_q <= '0;
            prev_id_q    <= {SrcIdxW{1'b0}};
        end else begin
            prev_hold_q  <= hold_s;
            prev_entry_q <= fetch_entry_o;
            prev_id_q    <= src_id_o;
        end
    end

    // Accept vector sanity and output stability under backpressure.
    always_comb begin
        a_ready_onehot0 : assert ($onehot0(src_ready_o));
        a_ready_valid   : assert ((src_ready_o & ~src_valid_i) == {NrSrc{1'b0}});
        a_out_stable    : assert (!prev_hold_q || (fetch_entry_valid_o
                                  && (fetch_entry_o == prev_entry_q)
                                  && (src_id_o == prev_id_q)));
    end

endmodule

// File: rtl/id_fetch_arbiter.sv
// Shares the ID stage fetch port between NrSrc instruction sources through an
// aging fixed-priority arbiter and a single output holding register.
module id_fetch_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NrSrc   = 2,
    parameter int unsigned MaxWait = FetchArbMaxWait,
    parameter int unsigned SrcIdxW = (NrSrc > 1) ? $clog2(NrSrc) : 1,
    parameter int unsigned AgeW    = $clog2(MaxWait + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  fetch_entry_t [NrSrc-1:0] src_entry_i,
    input  logic [NrSrc-1:0]         src_valid_i,
    output logic [NrSrc-1:0]         src_ready_o,
    output fetch_entry_t             fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [SrcIdxW-1:0]       src_id_o
);

    logic               load_s;
    logic [NrSrc-1:0]   gnt_s;
    logic [SrcIdxW-1:0] gnt_idx_s;
    logic               gnt_valid_s;

    fetch_entry_t       fetch_entry_q, fetch_entry_d;
    logic               valid_q, valid_d;
    logic [SrcIdxW-1:0] src_id_q, src_id_d;

    // Gating with rst_ni keeps sources from handing off an entry that reset drops.
    assign load_s      = rst_ni && (!valid_q || fetch_entry_ready_i) && !flush_i;
    assign src_ready_o = gnt_s & {NrSrc{load_s}};

    age_prio_arbiter #(
        .NrSrc   (NrSrc),
        .MaxWait (MaxWait),
        .SrcIdxW (SrcIdxW),
        .AgeW    (AgeW)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (src_valid_i),
        .advance_i   (load_s),
        .flush_i     (flush_i),
        .gnt_o       (gnt_s),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // Output register next state.
    always_comb begin
        fetch_entry_d = fetch_entry_q;
        valid_d       = valid_q;
        src_id_d      = src_id_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = gnt_valid_s;
            if (gnt_valid_s) begin
                fetch_entry_d = src_entry_i[gnt_idx_s];
                src_id_d      = gnt_idx_s;
            end else begin
                src_id_d      = src_id_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Output holding register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_entry_q <= '0;
            valid_q       <= 1'b0;
            src_id_q      <= {SrcIdxW{1'b0}};
        end else begin
            fetch_entry_q <= fetch_entry_d;
            valid_q       <= valid_d;
            src_id_q      <= src_id_d;
        end
    end

    assign fetch_entry_o       = fetch_entry_q;
    assign fetch_entry_valid_o = valid_q;
    assign src_id_o            = src_id_q;

    id_fetch_arbiter_sva #(
        .NrSrc   (NrSrc),
        .SrcIdxW (SrcIdxW)
    ) u_sva (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .src_valid_i         (src_valid_i),
        .src_ready_o         (src_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .src_id_o            (src_id_o)
    );

endmodule

// File: tb/tb_id_fetch_arbiter.sv
// Directed and random checks of id_fetch_arbiter against a behavioural model
// of the arbitration, aging and output register rules.
module tb_id_fetch_arbiter;
    import ariane_pkg::*;

    localparam int NSRC = 2;
    localparam int MAXW = 3;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    fetch_entry_t [NSRC-1:0]  src_entry;
    logic [NSRC-1:0]          src_valid;
    logic [NSRC-1:0]          src_ready;
    fetch_entry_t             out_entry;
    logic                     out_valid;
    logic                     out_ready;
    logic                     src_id;

    id_fetch_arbiter #(.NrSrc(NSRC), .MaxWait(MAXW)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flush_i             (flush),
        .src_entry_i         (src_entry),
        .src_valid_i         (src_valid),
        .src_ready_o         (src_ready),
        .fetch_entry_o       (out_entry),
        .fetch_entry_valid_o (out_valid),
        .fetch_entry_ready_i (out_ready),
        .src_id_o            (src_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int           age [NSRC];
    bit           m_valid;
    fetch_entry_t m_entry;
    int           m_id;
    logic [NSRC-1:0] last_acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int g = -1;
        for (int i = 0; i < NSRC; i++)
            if (g < 0 && src_valid[i] && age[i] == MAXW) g = i;
        for (int i = 0; i < NSRC; i++)
            if (g < 0 && src_valid[i]) g = i;
        return g;
    endfunction

    function automatic fetch_entry_t rand_entry();
        fetch_entry_t e;
        e.address     = $urandom;
        e.instruction = $urandom;
        e.ex_valid    = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic model_update(input int g, input bit ld);
        if (!rst_n) begin
            m_valid = 0; m_entry = '0; m_id = 0;
            for (int i = 0; i < NSRC; i++) age[i] = 0;
        end else if (flush) begin
            m_valid = 0;
            for (int i = 0; i < NSRC; i++) age[i] = 0;
        end else if (ld && g >= 0) begin
            m_valid = 1; m_entry = src_entry[g]; m_id = g;
            for (int i = 0; i < NSRC; i++)
                if (i == g) age[i] = 0;
                else if (src_valid[i]) age[i] = (age[i] + 1 > MAXW) ? MAXW : age[i] + 1;
                else age[i] = 0;
        end else begin
            if (ld) m_valid = 0;
            for (int i = 0; i < NSRC; i++)
                if (!src_valid[i]) age[i] = 0;
        end
    endtask

    // one clock: check the accept vector mid-cycle, then the registered outputs
    task automatic tick();
        int g;
        bit ld;
        logic [NSRC-1:0] er;
        #2;
        g  = model_grant();
        ld = rst_n && (!m_valid || out_ready) && !flush;
        er = (ld && g >= 0) ? NSRC'(1 << g) : '0;
        chk("src_ready", src_ready, er);
        last_acc = er;
        @(posedge clk);
        model_update(g, ld);
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_entry", out_entry, m_entry);
            chk("src_id", src_id, m_id);
        end
    endtask

    // new entries only where the previous one was taken or the source is idle
    task automatic refresh();
        for (int i = 0; i < NSRC; i++)
            if (last_acc[i] || !src_valid[i]) src_entry[i] = rand_entry();
    endtask

    initial begin
        int pat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int wd[4]  = '{0, 0, 0, 1};
        m_valid = 0; m_entry = '0; m_id = 0; last_acc = '0;
        for (int i = 0; i < NSRC; i++) age[i] = 0;
        for (int i = 0; i < NSRC; i++) src_entry[i] = rand_entry();

        // reset with both sources requesting
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; src_valid = 2'b11;
        tick(); tick();
        chk("rst_entry", out_entry, 65'd0);
        chk("rst_id", src_id, 1'b0);

        // aging pattern with the consumer always ready
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            refresh(); tick();
            chk("age_seq", src_id, pat[k]);
        end

        // backpressure with the register full
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            refresh(); tick();
            chk("bp_noacc", src_ready, 2'b00);
        end
        out_ready = 1'b1;
        refresh(); tick();

        // flush against a ready consumer and valid sources
        flush = 1'b1;
        refresh(); tick();
        chk("flush_valid", out_valid, 1'b0);
        flush = 1'b0;

        // withdraw: src1 loses twice, drops out, then needs three new losses
        refresh(); tick(); refresh(); tick();
        src_valid = 2'b01;
        refresh(); tick();
        src_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            refresh(); tick();
            chk("withdraw_seq", src_id, wd[k]);
        end

        // reset while an entry is stalled in the register
        out_ready = 1'b0;
        refresh(); tick();
        rst_n = 1'b0;
        refresh(); tick();
        chk("midrst_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        refresh(); tick();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            src_valid = NSRC'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            refresh();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
